smachine_dmem_ctrl: RTL and testbench

//   Parametrised data-memory controller for the S-Machine, replacing the fixed 16x256 combinational store.

---
 rtl/smachine_dmem_ctrl.sv | 115 +++++++++++
 tb/tb_smachine_dmem_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/smachine_dmem_ctrl.sv
// S-Machine data-memory controller: req/accept handshake, programmable wait states,
// out-of-range detection and a saturating completed-access counter.
module smachine_dmem_ctrl #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1,
    parameter int ACC_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              accept,
    output logic              ready,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              busy,
    output logic [ACC_W-1:0]  access_count
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W+1)'(DEPTH);
    localparam logic [3:0]      CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t             state, state_nx;
    logic [3:0]         cnt, cnt_nx;
    logic               commit;
    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               acc_we, acc_oor;
    logic [ADDR_W-1:0]  acc_addr;
    logic [DATA_W-1:0]  acc_wdata;
    logic [IDX_W-1:0]   acc_idx;
    logic [DATA_W-1:0]  mem [DEPTH];

    assign accept = (state == IDLE) || (state == DONE);

    // Zero wait states commit on the request edge itself, so use the live inputs;
    // otherwise the commit comes out of WAIT and uses the latched request.
    assign acc_we    = (state == WAIT) ? we_q    : we;
    assign acc_addr  = (state == WAIT) ? addr_q  : addr;
    assign acc_wdata = (state == WAIT) ? wdata_q : wdata;
    assign acc_idx   = acc_addr[IDX_W-1:0];
    assign acc_oor   = {1'b0, acc_addr} >= DEPTH_L;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        commit   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (req) begin
                    if (WAIT_STATES == 0) begin
                        state_nx = DONE;
                        commit   = 1'b1;
                    end else begin
                        state_nx = WAIT;
                        cnt_nx   = CNT_INIT;
                    end
                end else begin
                    state_nx = IDLE;
                end
            end
            WAIT: begin
                if (cnt != 4'd0) begin
                    cnt_nx = cnt - 4'd1;
                end else begin
                    state_nx = DONE;
                    commit   = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            ready        <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
            rdata        <= '0;
            access_count <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            ready <= (state_nx == DONE);
            busy  <= (state_nx != IDLE);
            if (commit) begin
                err <= acc_oor;
                if (!acc_we)
                    rdata <= acc_oor ? '0 : mem[acc_idx];
                if (access_count != '1)
                    access_count <= access_count + 1'b1;
            end
        end
    end

    // Request capture and the array itself carry no reset; contents survive rst_n.
    always_ff @(posedge clk) begin
        if (req && accept) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
        if (commit && acc_we && !acc_oor)
            mem[acc_idx] <= acc_wdata;
    end
endmodule

// File: tb/tb_smachine_dmem_ctrl.sv
// Directed bench for smachine_dmem_ctrl: three parameterisations driven from shared
// we/addr/wdata with per-instance req, expected values hand-computed.
module tb_smachine_dmem_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic        req_a, req_b, req_c;

    logic        accept_a, ready_a, err_a, busy_a;
    logic [15:0] rdata_a, cnt_a;
    logic        accept_b, ready_b, err_b, busy_b;
    logic [15:0] rdata_b;
    logic [3:0]  cnt_b;
    logic        accept_c, ready_c, err_c, busy_c;
    logic [15:0] rdata_c, cnt_c;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // A: zero wait states, full depth
    smachine_dmem_ctrl #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .WAIT_STATES(0), .ACC_W(16)) u_a (
        .clk(clk), .rst_n(rst_n), .req(req_a), .we(we), .addr(addr), .wdata(wdata),
        .accept(accept_a), .ready(ready_a), .rdata(rdata_a), .err(err_a), .busy(busy_a),
        .access_count(cnt_a));

    // B: three wait states, short depth, narrow counter
    smachine_dmem_ctrl #(.DATA_W(16), .ADDR_W(8), .DEPTH(200), .WAIT_STATES(3), .ACC_W(4)) u_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .we(we), .addr(addr), .wdata(wdata),
        .accept(accept_b), .ready(ready_b), .rdata(rdata_b), .err(err_b), .busy(busy_b),
        .access_count(cnt_b));

    // C: one wait state
    smachine_dmem_ctrl #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .WAIT_STATES(1), .ACC_W(16)) u_c (
        .clk(clk), .rst_n(rst_n), .req(req_c), .we(we), .addr(addr), .wdata(wdata),
        .accept(accept_c), .ready(ready_c), .rdata(rdata_c), .err(err_c), .busy(busy_c),
        .access_count(cnt_c));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic rdy(input int u);
        return (u == 0) ? ready_a : (u == 1) ? ready_b : ready_c;
    endfunction

    task automatic set_req(input int u, input logic v);
        case (u)
            0:       req_a = v;
            1:       req_b = v;
            default: req_c = v;
        endcase
    endtask

    // One request pulse, then wait (bounded) for ready; lat counts negedges to ready.
    task automatic do_acc(input int u, input logic w, input logic [7:0] a, input logic [15:0] d,
                          output logic [15:0] rd, output logic er, output int lat);
        @(negedge clk);
        we = w; addr = a; wdata = d;
        set_req(u, 1'b1);
        @(negedge clk);
        set_req(u, 1'b0);
        lat = 1;
        while (!rdy(u) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!rdy(u)) check("timeout", 0, 1);
        rd = (u == 0) ? rdata_a : (u == 1) ? rdata_b : rdata_c;
        er = (u == 0) ? err_a : (u == 1) ? err_b : err_c;
    endtask

    logic [15:0] rd;
    logic        er;
    int          lat;
    logic [15:0] t4_dat [2] = '{16'h1111, 16'h2222};

    initial begin
        we = 1'b0; addr = '0; wdata = '0;
        req_a = 1'b0; req_b = 1'b0; req_c = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready_a", ready_a, 0);
        check("rst_busy_b",  busy_b, 0);
        check("rst_rdata_a", rdata_a, 0);
        check("rst_cnt_b",   cnt_b, 0);
        check("rst_accept_c", accept_c, 1);
        rst_n = 1'b1;

        // T1: W=0 write then read
        do_acc(0, 1'b1, 8'h10, 16'hBEEF, rd, er, lat);
        check("t1_wr_lat", lat, 1);
        check("t1_wr_err", er, 0);
        check("t1_cnt1", cnt_a, 1);
        do_acc(0, 1'b0, 8'h10, 16'h0000, rd, er, lat);
        check("t1_rd_lat", lat, 1);
        check("t1_rdata", rd, 16'hBEEF);
        check("t1_cnt2", cnt_a, 2);
        @(negedge clk);
        check("t1_ready_low", ready_a, 0);
        check("t1_busy_low", busy_a, 0);
        check("t1_rdata_hold", rdata_a, 16'hBEEF);

        // T2: W=3 timing, dropped request in WAIT (out-of-range read so rdata is known)
        @(negedge clk);
        we = 1'b0; addr = 8'hC9; req_b = 1'b1;
        @(negedge clk);
        check("t2_busy", busy_b, 1);
        check("t2_rdy_t1", ready_b, 0);
        check("t2_accept_wait", accept_b, 0);
        req_b = 1'b0;
        @(negedge clk);
        check("t2_rdy_t2", ready_b, 0);
        req_b = 1'b1; we = 1'b1; addr = 8'h00; wdata = 16'hFFFF;
        @(negedge clk);
        check("t2_rdy_t3", ready_b, 0);
        req_b = 1'b0; we = 1'b0;
        @(negedge clk);
        check("t2_rdy_t4", ready_b, 1);
        check("t2_err", err_b, 1);
        check("t2_rdata", rdata_b, 0);
        check("t2_accept_done", accept_b, 1);
        check("t2_cnt", cnt_b, 1);
        @(negedge clk);
        check("t2_rdy_off", ready_b, 0);
        check("t2_busy_off", busy_b, 0);
        repeat (4) @(negedge clk);
        check("t2_cnt_after", cnt_b, 1);
        check("t2_no_ready", ready_b, 0);

        // T3: DEPTH=200, out-of-range accesses must not alias into the array
        do_acc(1, 1'b1, 8'd199, 16'h0199, rd, er, lat);
        check("t3_lat", lat, 4);
        do_acc(1, 1'b1, 8'h48, 16'h0048, rd, er, lat);
        do_acc(1, 1'b1, 8'hC8, 16'h1234, rd, er, lat);
        check("t3_wr_err", er, 1);
        check("t3_wr_rdata", rd, 0);
        do_acc(1, 1'b0, 8'hC8, 16'h0000, rd, er, lat);
        check("t3_rd_err", er, 1);
        check("t3_rd_rdata", rd, 0);
        do_acc(1, 1'b0, 8'd199, 16'h0000, rd, er, lat);
        check("t3_mem199", rd, 16'h0199);
        check("t3_mem199_err", er, 0);
        do_acc(1, 1'b0, 8'h48, 16'h0000, rd, er, lat);
        check("t3_mem48", rd, 16'h0048);
        check("t3_cnt", cnt_b, 7);

        // T4: W=1, req held, alternating write/read @0x05
        @(negedge clk);
        req_c = 1'b1; we = 1'b1; addr = 8'h05; wdata = t4_dat[0];
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("t4_rdy%0d", k), ready_c, k[0]);
            if (k[0]) begin
                if (k == 3) check("t4_raw0", rdata_c, t4_dat[0]);
                if (k == 7) check("t4_raw1", rdata_c, t4_dat[1]);
                we = ((k / 2) % 2 == 1);
                wdata = t4_dat[((k / 2) + 1) / 2 % 2];
            end
        end
        req_c = 1'b0;
        check("t4_cnt", cnt_c, 4);

        // T5: narrow counter saturates at 15
        for (int i = 0; i < 20; i++) begin
            do_acc(1, 1'b0, 8'h48, 16'h0000, rd, er, lat);
            if (i == 7) check("t5_cnt_sat", cnt_b, 15);
        end
        check("t5_cnt_hold", cnt_b, 15);
        check("t5_rdata", rd, 16'h0048);

        // T6: reset during WAIT abandons the write
        do_acc(1, 1'b1, 8'h20, 16'h5555, rd, er, lat);
        @(negedge clk);
        req_b = 1'b1; we = 1'b1; addr = 8'h20; wdata = 16'hAAAA;
        @(negedge clk);
        req_b = 1'b0;
        check("t6_in_wait", busy_b, 1);
        rst_n = 1'b0;
        #1;
        check("t6_ready", ready_b, 0);
        check("t6_busy", busy_b, 0);
        check("t6_rdata", rdata_b, 0);
        check("t6_cnt", cnt_b, 0);
        check("t6_accept", accept_b, 1);
        #1 rst_n = 1'b1;
        do_acc(1, 1'b0, 8'h20, 16'h0000, rd, er, lat);
        check("t6_mem_kept", rd, 16'h5555);
        check("t6_cnt_after", cnt_b, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
